// File: rtl/icache_nway.sv
// Blocking N-way instruction cache with round-robin replacement, uncached word fetch and set/all invalidate.
// Latency: hit data_ok one cycle after addr_ok (one fetch per cycle sustained); miss data_ok with the last refill beat.
// Backpressure: addr_ok is withheld while a miss, refill or invalidate is in progress; rd_req held until rd_rdy.
module icache_nway #(
    parameter  int WAYS       = 2,
    parameter  int LINE_WORDS = 8,
    parameter  int SETS       = 128,
    localparam int OFF_W      = $clog2(LINE_WORDS) + 2,
    localparam int IDX_W      = $clog2(SETS),
    localparam int TAG_W      = 32 - IDX_W - OFF_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] offset,
    input  logic             uncached,
    output logic             addr_ok,
    output logic             data_ok,
    output logic [31:0]      rdata_l,
    output logic [31:0]      rdata_h,
    output logic             rdata_h_valid,
    input  logic             inv_req,
    input  logic             inv_all,
    input  logic [IDX_W-1:0] inv_index,
    output logic             inv_ok,
    output logic             rd_req,
    output logic [2:0]       rd_type,
    output logic [31:0]      rd_addr,
    input  logic             rd_rdy,
    input  logic             ret_valid,
    input  logic             ret_last,
    input  logic [31:0]      ret_data
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int RR_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(LINE_WORDS - 1);
    localparam logic [WORD_W-1:0] ONE_WORD  = WORD_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL, S_INV} state_t;

    state_t                           state_q, state_d;
    logic [TAG_W-1:0]                 req_tag_q, req_tag_d;
    logic [IDX_W-1:0]                 req_idx_q, req_idx_d;
    logic [OFF_W-1:0]                 req_off_q, req_off_d;
    logic                             req_unc_q, req_unc_d;
    logic                             inv_all_q, inv_all_d;
    logic [IDX_W-1:0]                 inv_idx_q, inv_idx_d;
    logic [WORD_W-1:0]                beat_q, beat_d;
    logic [31:0]                      line_q [LINE_WORDS];
    logic [31:0]                      line_d [LINE_WORDS];
    logic [WAYS-1:0][SETS-1:0]        valid_q, valid_d;
    logic [SETS-1:0][RR_W-1:0]        rr_q, rr_d;

    // Tag and data arrays carry no reset: a line is only trusted through its valid bit.
    logic [TAG_W-1:0]                 tag_ram  [WAYS][SETS];
    logic [31:0]                      data_ram [WAYS][SETS][LINE_WORDS];

    logic [WAYS-1:0]                  hit_vec;
    logic                             hit;
    logic [31:0]                      hit_l, hit_h;
    logic [31:0]                      fill_line [LINE_WORDS];
    logic                             fill_we;
    logic [RR_W-1:0]                  fill_way, rr_next;
    logic [WORD_W-1:0]                word_sel, word_nxt;
    logic                             is_last;

    assign word_sel = req_off_q[OFF_W-1:2];
    assign word_nxt = word_sel + ONE_WORD;
    assign is_last  = (word_sel == LAST_WORD);
    assign fill_way = rr_q[req_idx_q];
    assign rr_next  = (fill_way == RR_W'(WAYS - 1)) ? '0 : fill_way + RR_W'(1);
    assign hit      = |hit_vec;

    // Tag compare across all ways of the latched set; uncached requests never hit.
    always_comb begin
        hit_vec = '0;
        hit_l   = '0;
        hit_h   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx_q] && (tag_ram[w][req_idx_q] == req_tag_q) && !req_unc_q) begin
                hit_vec[w] = 1'b1;
                hit_l      = hit_l | data_ram[w][req_idx_q][word_sel];
                hit_h      = hit_h | data_ram[w][req_idx_q][word_nxt];
            end
        end
    end

    // Line as it will be written: buffered beats plus the beat arriving this cycle.
    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            fill_line[i] = (WORD_W'(i) == beat_q) ? ret_data : line_q[i];
        end
    end

    // Next-state, bookkeeping updates and all handshake/data outputs.
    always_comb begin
        state_d       = state_q;
        req_tag_d     = req_tag_q;
        req_idx_d     = req_idx_q;
        req_off_d     = req_off_q;
        req_unc_d     = req_unc_q;
        inv_all_d     = inv_all_q;
        inv_idx_d     = inv_idx_q;
        beat_d        = beat_q;
        line_d        = line_q;
        valid_d       = valid_q;
        rr_d          = rr_q;
        fill_we       = 1'b0;
        addr_ok       = 1'b0;
        data_ok       = 1'b0;
        rdata_l       = '0;
        rdata_h       = '0;
        rdata_h_valid = 1'b0;
        inv_ok        = 1'b0;
        rd_req        = 1'b0;
        rd_type       = 3'b000;
        rd_addr       = '0;

        case (state_q)
            S_IDLE: begin
                if (inv_req) begin
                    inv_all_d = inv_all;
                    inv_idx_d = inv_index;
                    state_d   = S_INV;
                end else if (valid) begin
                    addr_ok = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    data_ok       = 1'b1;
                    rdata_l       = hit_l;
                    rdata_h       = is_last ? '0 : hit_h;
                    rdata_h_valid = !is_last;
                    if (valid && !inv_req) begin
                        addr_ok = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                rd_req  = 1'b1;
                rd_type = req_unc_q ? 3'b010 : 3'b100;
                rd_addr = req_unc_q ? {req_tag_q, req_idx_q, req_off_q}
                                    : {req_tag_q, req_idx_q, {OFF_W{1'b0}}};
                if (rd_rdy) begin
                    beat_d  = '0;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (ret_valid) begin
                    line_d[beat_q] = ret_data;
                    beat_d         = beat_q + ONE_WORD;
                    if (ret_last) begin
                        data_ok = 1'b1;
                        state_d = S_IDLE;
                        if (req_unc_q) begin
                            rdata_l = ret_data;
                        end else begin
                            rdata_l                      = fill_line[word_sel];
                            rdata_h                      = is_last ? '0 : fill_line[word_nxt];
                            rdata_h_valid                = !is_last;
                            fill_we                      = 1'b1;
                            valid_d[fill_way][req_idx_q] = 1'b1;
                            rr_d[req_idx_q]              = rr_next;
                        end
                    end
                end
            end
            S_INV: begin
                if (inv_all_q) begin
                    valid_d = '0;
                end else begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_d[w][inv_idx_q] = 1'b0;
                    end
                end
                inv_ok  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (addr_ok) begin
            req_tag_d = tag;
            req_idx_d = index;
            req_off_d = offset;
            req_unc_d = uncached;
        end
    end

    // Control state, request latch, refill buffer, valid bits and replacement pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= '0;
            req_unc_q <= 1'b0;
            inv_all_q <= 1'b0;
            inv_idx_q <= '0;
            beat_q    <= '0;
            valid_q   <= '0;
            rr_q      <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            req_off_q <= req_off_d;
            req_unc_q <= req_unc_d;
            inv_all_q <= inv_all_d;
            inv_idx_q <= inv_idx_d;
            beat_q    <= beat_d;
            valid_q   <= valid_d;
            rr_q      <= rr_d;
            line_q    <= line_d;
        end
    end

    // Refill write port: whole line plus tag into the round-robin victim way.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_ram[fill_way][req_idx_q] <= req_tag_q;
            for (int i = 0; i < LINE_WORDS; i++) begin
                data_ram[fill_way][req_idx_q][i] <= fill_line[i];
            end
        end
    end

    // A line may live in at most one way of its set.
    a_onehot_hit: assert property (@(posedge clk) disable iff (!resetn) $onehot0(hit_vec));

endmodule

// File: tb/tb_icache_nway.sv
module tb_icache_nway;
    localparam int WAYS = 2, LINE_WORDS = 8, SETS = 128;
    localparam int OFF_W = 5, IDX_W = 7, TAG_W = 20;

    logic             clk = 1'b0;
    logic             resetn;
    logic             valid, uncached;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] index;
    logic [OFF_W-1:0] offset;
    logic             addr_ok, data_ok, rdata_h_valid;
    logic [31:0]      rdata_l, rdata_h;
    logic             inv_req, inv_all, inv_ok;
    logic [IDX_W-1:0] inv_index;
    logic             rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]       rd_type;
    logic [31:0]      rd_addr, ret_data;

    always #5 clk = ~clk;

    icache_nway #(.WAYS(WAYS), .LINE_WORDS(LINE_WORDS), .SETS(SETS)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .tag(tag), .index(index), .offset(offset),
        .uncached(uncached), .addr_ok(addr_ok), .data_ok(data_ok), .rdata_l(rdata_l),
        .rdata_h(rdata_h), .rdata_h_valid(rdata_h_valid), .inv_req(inv_req), .inv_all(inv_all),
        .inv_index(inv_index), .inv_ok(inv_ok), .rd_req(rd_req), .rd_type(rd_type),
        .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
        .ret_data(ret_data)
    );

    typedef struct packed {
        logic [31:0] l;
        logic [31:0] h;
        logic        hv;
        logic        hit;
        logic [7:0]  id;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  typ;
        logic [31:0] base;
        logic [3:0]  nbeats;
        logic        last;
        logic [1:0]  dly;
    } miss_t;

    exp_t  exp_q[$];
    miss_t miss_q[$];
    int    acc_q[$];
    int    n_cmp = 0, n_bad = 0;
    int    cyc = 0;
    int    resp_cnt = 0;
    int    stray_req = 0, stray_done = 0;
    int    id_ctr = 0;
    int    last_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: pairs each data_ok with the oldest expectation and the cycle its address was taken.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            if (addr_ok) acc_q.push_back(cyc);
            if (data_ok) begin
                if (exp_q.size() == 0) begin
                    chk("data_ok_unexpected", data_ok, 0);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
                    chk($sformatf("rdata_l[%0d]", e.id), rdata_l, e.l);
                    chk($sformatf("rdata_h[%0d]", e.id), rdata_h, e.h);
                    chk($sformatf("rdata_h_valid[%0d]", e.id), rdata_h_valid, e.hv);
                    chk($sformatf("hit_latency[%0d]", e.id), (cyc - a == 1), e.hit);
                end
            end
        end
    end

    // Responder: answers each read request from the expected-miss queue, plus stray beats on demand.
    initial begin
        miss_t m;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                for (int i = 0; i < 2; i++) begin
                    @(posedge clk); #1;
                    ret_valid = 1; ret_data = 32'h0000bad0 + 32'(i); ret_last = (i == 1);
                end
                @(posedge clk); #1;
                ret_valid = 0; ret_last = 0;
                stray_done++;
            end else if (rd_req) begin
                if (miss_q.size() == 0) begin
                    chk("rd_req_unexpected", rd_req, 0);
                end else begin
                    m = miss_q.pop_front();
                    chk("rd_addr", rd_addr, m.addr);
                    chk("rd_type", rd_type, m.typ);
                    for (int d = 0; d < int'(m.dly); d++) begin
                        @(posedge clk); @(negedge clk);
                        chk("rd_req_hold", rd_req, 1);
                    end
                    @(posedge clk); #1 rd_rdy = 1;
                    @(posedge clk); #1 rd_rdy = 0;
                    for (int i = 0; i < int'(m.nbeats); i++) begin
                        ret_valid = 1;
                        ret_data  = m.base + 32'(i);
                        ret_last  = m.last && (i == int'(m.nbeats) - 1);
                        if (i == 0) begin
                            @(negedge clk);
                            chk("rd_req_drop", rd_req, 0);
                        end
                        @(posedge clk); #1;
                    end
                    ret_valid = 0; ret_last = 0;
                    resp_cnt++;
                end
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic unc, input logic hold, input logic miss,
                         input logic [31:0] base, input int nbeats, input logic last,
                         input logic [31:0] el, input logic [31:0] eh, input logic ehv);
        exp_t  e;
        miss_t m;
        int    t;
        e.l = el; e.h = eh; e.hv = ehv; e.hit = !miss; e.id = 8'(id_ctr);
        id_ctr++;
        exp_q.push_back(e);
        if (miss) begin
            m.addr   = unc ? a : {a[31:5], 5'b0};
            m.typ    = unc ? 3'b010 : 3'b100;
            m.base   = base;
            m.nbeats = 4'(nbeats);
            m.last   = last;
            m.dly    = 2'(id_ctr % 3);
            miss_q.push_back(m);
        end
        valid = 1; {tag, index, offset} = a; uncached = unc;
        t = 0;
        @(negedge clk);
        while (!addr_ok && t < 300) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        if (t >= 300) chk("addr_ok_timeout", addr_ok, 1);
        @(posedge clk); #1;
        if (!hold) valid = 0;
    endtask

    task automatic fc(input logic [31:0] a, input logic miss, input logic [31:0] base,
                      input logic [31:0] el, input logic [31:0] eh, input logic ehv);
        fetch(a, 1'b0, 1'b0, miss, base, 8, 1'b1, el, eh, ehv);
    endtask

    task automatic fu(input logic [31:0] a, input logic [31:0] base);
        fetch(a, 1'b1, 1'b0, 1'b1, base, 1, 1'b1, base, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_inv(input logic all, input logic [IDX_W-1:0] idx);
        int t;
        inv_req = 1; inv_all = all; inv_index = idx;
        t = 0;
        @(negedge clk);
        while (!inv_ok && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("inv_ok_seen", inv_ok, 1);
        chk("inv_latency", t, 1);
        @(posedge clk); #1;
        inv_req = 0; inv_all = 0;
        @(negedge clk);
        chk("inv_ok_pulse", inv_ok, 0);
        @(posedge clk); #1;
    endtask

    task automatic check_quiet(input string tagname);
        chk({tagname, "_addr_ok"}, addr_ok, 0);
        chk({tagname, "_data_ok"}, data_ok, 0);
        chk({tagname, "_rd_req"}, rd_req, 0);
        chk({tagname, "_inv_ok"}, inv_ok, 0);
        chk({tagname, "_rdata_l"}, rdata_l, 0);
        chk({tagname, "_rd_addr"}, rd_addr, 0);
    endtask

    initial begin
        int t;
        resetn = 0; valid = 0; uncached = 0; tag = '0; index = '0; offset = '0;
        inv_req = 0; inv_all = 0; inv_index = '0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        resetn = 1;
        @(posedge clk); #1;

        // cold miss, then hit on refetch
        fc(32'h1c000000, 1, 32'h0, 32'h0, 32'h1, 1);
        fc(32'h1c000000, 0, 32'h0, 32'h0, 32'h1, 1);

        // back-to-back hits with valid held
        fetch(32'h1c000000, 0, 1, 0, 0, 0, 0, 32'h0, 32'h1, 1);
        fetch(32'h1c000004, 0, 1, 0, 0, 0, 0, 32'h1, 32'h2, 1);
        chk("b2b_wait_1", last_wait, 0);
        fetch(32'h1c000008, 0, 0, 0, 0, 0, 0, 32'h2, 32'h3, 1);
        chk("b2b_wait_2", last_wait, 0);

        // last word of line
        fc(32'h1c00001c, 0, 32'h0, 32'h7, 32'h0, 0);

        // round-robin replacement in set 0
        fc(32'h1c001000, 1, 32'h100, 32'h100, 32'h101, 1);
        fc(32'h1c002000, 1, 32'h200, 32'h200, 32'h201, 1);
        fc(32'h1c001000, 0, 32'h0,   32'h100, 32'h101, 1);
        fc(32'h1c000000, 1, 32'h10,  32'h10,  32'h11,  1);

        // uncached reads never allocate
        fu(32'hbfaf8000, 32'hdeadbeef);
        fu(32'hbfaf8000, 32'h12345678);
        fu(32'hbfaf8014, 32'h55aa55aa);

        // single-set invalidate leaves other sets alone
        fc(32'h1c000020, 1, 32'h300, 32'h300, 32'h301, 1);
        drain();
        do_inv(1'b0, 7'd0);
        fc(32'h1c000020, 0, 32'h0,   32'h300, 32'h301, 1);
        fc(32'h1c000000, 1, 32'h400, 32'h400, 32'h401, 1);

        // whole-cache invalidate after four resident lines
        fc(32'h1c000040, 1, 32'h500, 32'h500, 32'h501, 1);
        fc(32'h1c000060, 1, 32'h600, 32'h600, 32'h601, 1);
        fc(32'h1c000044, 0, 32'h0,   32'h501, 32'h502, 1);
        drain();
        do_inv(1'b1, 7'd5);
        fc(32'h1c000000, 1, 32'h700, 32'h700, 32'h701, 1);
        fc(32'h1c000020, 1, 32'h710, 32'h710, 32'h711, 1);
        fc(32'h1c000040, 1, 32'h720, 32'h720, 32'h721, 1);
        fc(32'h1c000064, 1, 32'h730, 32'h731, 32'h732, 1);
        drain();

        // reset in the middle of a refill
        t = resp_cnt;
        fetch(32'h1c000080, 0, 0, 1, 32'h800, 3, 0, 32'h0, 32'h0, 0);
        while (resp_cnt == t && t < 100000) begin
            @(posedge clk);
            if (cyc > 60000) t = 100000;
        end
        chk("partial_refill_done", resp_cnt, t + 1);
        #1;
        resetn = 0;
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk); #1;
        resetn = 1;
        stray_req++;
        t = 0;
        while (stray_done != stray_req && t < 100) begin
            @(posedge clk);
            t++;
        end
        chk("stray_done", stray_done, stray_req);
        @(posedge clk); #1;
        fc(32'h1c000080, 1, 32'h900, 32'h900, 32'h901, 1);
        fc(32'h1c000000, 1, 32'ha00, 32'ha00, 32'ha01, 1);
        drain();
        chk("miss_q_empty", miss_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
